param_data_fifo: RTL and testbench

PARAM_DATA_FIFO -- requirements
Module: param_data_fifo

---
 rtl/param_data_fifo.sv | 96 +++++++++
 tb/tb_param_data_fifo.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/param_data_fifo.sv
// Parameterised synchronous FIFO with wrap-bit pointers, occupancy count and overflow/underflow pulses.
// Define PARAM_DATA_FIFO_FWFT_EN for first-word-fall-through read data; otherwise RData is registered.
module param_data_fifo #(
  parameter int DataWidth  = 64,
  parameter int Depth      = 4,
  parameter int AFullLevel = Depth - 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Jump,
  input  logic [DataWidth-1:0]     WData,
  input  logic                     WInc,
  output logic                     WFull,
  output logic                     W_Will_Full,
  output logic                     WAlmostFull,
  input  logic                     RInc,
  output logic [DataWidth-1:0]     RData,
  output logic                     REmpty,
  output logic [$clog2(Depth):0]   Count,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int AW = $clog2(Depth);
  localparam int PW = AW + 1;

  logic [PW-1:0]        wptr_reg;
  logic [PW-1:0]        rptr_reg;
  logic                 overflow_reg;
  logic                 underflow_reg;
  logic [DataWidth-1:0] mem [Depth];
  logic                 wr_en;
  logic                 rd_en;
  logic [AW-1:0]        widx;
  logic [AW-1:0]        ridx;

  assign widx = wptr_reg[AW-1:0];
  assign ridx = rptr_reg[AW-1:0];

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign REmpty = (wptr_reg == rptr_reg);
  assign WFull  = (wptr_reg[AW] != rptr_reg[AW]) && (widx == ridx);
  assign Count  = wptr_reg - rptr_reg;

  assign W_Will_Full = (Count == PW'(Depth - 1));
  assign WAlmostFull = (Count >= PW'(AFullLevel));

  assign wr_en = WInc & ~WFull & ~Jump;
  assign rd_en = RInc & ~REmpty & ~Jump;

  assign Overflow  = overflow_reg;
  assign Underflow = underflow_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (Jump) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en) wptr_reg <= wptr_reg + PW'(1);
      if (rd_en) rptr_reg <= rptr_reg + PW'(1);
      overflow_reg  <= WInc & WFull;
      underflow_reg <= RInc & REmpty;
    end
  end

  // Storage is never reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[widx] <= WData;
  end

`ifdef PARAM_DATA_FIFO_FWFT_EN
  assign RData = REmpty ? '0 : mem[ridx];
`else
  logic [DataWidth-1:0] rdata_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rdata_reg <= '0;
    end else if (Jump) begin
      rdata_reg <= '0;
    end else if (rd_en) begin
      rdata_reg <= mem[ridx];
    end
  end

  assign RData = rdata_reg;
`endif

endmodule

// File: tb/tb_param_data_fifo.sv
// Bench for param_data_fifo (8-bit, depth 4, almost-full at 3): directed scenarios then random traffic
// against a queue-based reference model.
module tb_param_data_fifo;

  logic       Clk;
  logic       Rst;
  logic       Jump;
  logic [7:0] WData;
  logic       WInc;
  logic       WFull;
  logic       W_Will_Full;
  logic       WAlmostFull;
  logic       RInc;
  logic [7:0] RData;
  logic       REmpty;
  logic [2:0] Count;
  logic       Overflow;
  logic       Underflow;

  param_data_fifo #(.DataWidth(8), .Depth(4), .AFullLevel(3)) dut (
    .Clk(Clk), .Rst(Rst), .Jump(Jump), .WData(WData), .WInc(WInc),
    .WFull(WFull), .W_Will_Full(W_Will_Full), .WAlmostFull(WAlmostFull),
    .RInc(RInc), .RData(RData), .REmpty(REmpty), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] exp_rdata_reg;
  logic       exp_ovf;
  logic       exp_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rdata();
`ifdef PARAM_DATA_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 8'h00;
`else
    return exp_rdata_reg;
`endif
  endfunction

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},  32'(Count),       32'(n));
    chk({tag, ".empty"},  32'(REmpty),      32'(n == 0));
    chk({tag, ".full"},   32'(WFull),       32'(n == 4));
    chk({tag, ".wfull1"}, 32'(W_Will_Full), 32'(n == 3));
    chk({tag, ".afull"},  32'(WAlmostFull), 32'(n >= 3));
    chk({tag, ".ovf"},    32'(Overflow),    32'(exp_ovf));
    chk({tag, ".udf"},    32'(Underflow),   32'(exp_udf));
    chk({tag, ".rdata"},  32'(RData),       32'(exp_rdata()));
  endtask

  // One clock of traffic: inputs are driven 1 time unit after an edge, outputs checked 1 unit after the next.
  task automatic step(input logic j, input logic w, input logic r, input logic [7:0] d, input string tag);
    bit full_pre, empty_pre;
    Jump = j; WInc = w; RInc = r; WData = d;
    full_pre  = (q.size() == 4);
    empty_pre = (q.size() == 0);
    @(posedge Clk);
    if (j) begin
      q.delete();
      exp_rdata_reg = 8'h00;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      exp_ovf = w && full_pre;
      exp_udf = r && empty_pre;
      if (r && !empty_pre) exp_rdata_reg = q.pop_front();
      if (w && !full_pre) q.push_back(d);
    end
    #1;
    check_all(tag);
    $display("step %-8s jump=%0d winc=%0d rinc=%0d wdata=%02h -> count=%0d rdata=%02h ovf=%0d udf=%0d",
             tag, j, w, r, d, Count, RData, Overflow, Underflow);
  endtask

  task automatic async_reset(input string tag);
    #2;
    Rst = 1'b0;
    #1;
    q.delete();
    exp_rdata_reg = 8'h00;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_all(tag);
    $display("reset %s -> count=%0d empty=%0d rdata=%02h", tag, Count, REmpty, RData);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
  endtask

  initial begin
    Rst = 1'b0; Jump = 1'b0; WInc = 1'b0; RInc = 1'b0; WData = 8'h00;
    exp_rdata_reg = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_all("reset");
    Rst = 1'b1;

    // Fill to almost full, then full.
    step(0, 1, 0, 8'h11, "w11");
    step(0, 1, 0, 8'h22, "w22");
    step(0, 1, 0, 8'h33, "w33");
    step(0, 1, 0, 8'h44, "w44");
    step(0, 1, 0, 8'h55, "ovf55");
    step(0, 0, 0, 8'h00, "ovfend");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, "drain");
    step(0, 0, 0, 8'h00, "idle");

    step(0, 0, 1, 8'h00, "udf");
    step(0, 0, 0, 8'h00, "udfend");

    // Simultaneous access at the full and empty boundaries.
    step(0, 1, 0, 8'ha1, "fa1");
    step(0, 1, 0, 8'ha2, "fa2");
    step(0, 1, 0, 8'ha3, "fa3");
    step(0, 1, 0, 8'ha4, "fa4");
    step(0, 1, 1, 8'h66, "wr66");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h00, "drain2");
    step(0, 1, 1, 8'h77, "wr77");
    step(0, 0, 1, 8'h00, "rd77");
    step(0, 0, 0, 8'h00, "idle2");

    // Streaming across pointer wrap.
    step(0, 1, 0, 8'hc0, "s0");
    for (int i = 1; i < 10; i++) step(0, 1, 1, 8'(8'hc0 + i), "stream");
    step(0, 0, 1, 8'h00, "slast");
    step(0, 0, 0, 8'h00, "idle3");

    // Flush with a write in the same cycle.
    step(0, 1, 0, 8'h11, "j11");
    step(0, 1, 0, 8'h22, "j22");
    step(0, 1, 0, 8'h33, "j33");
    step(1, 1, 0, 8'h99, "jump");
    step(0, 1, 0, 8'h11, "pj11");
    step(0, 0, 1, 8'h00, "pjrd");
    step(0, 0, 0, 8'h00, "pjidle");

    // Reset in the middle of traffic.
    step(0, 1, 0, 8'h5a, "m5a");
    step(0, 1, 0, 8'h5b, "m5b");
    async_reset("midrst");
    step(0, 1, 1, 8'h3c, "postrst");
    step(0, 0, 1, 8'h00, "postrd");

    // Random traffic in write-heavy and read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      bit wh;
      wh = ((i / 25) % 2) == 0;
      step(($urandom_range(0, 39) == 0),
           wh ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           wh ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           8'($urandom), "rand");
      if ($urandom_range(0, 149) == 0) async_reset("randrst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
